credit_pool: RTL and testbench

Multi-channel credit tracker for the transmit side of a credit-based link. It keeps one saturating credit counter per virtual channel. Each cycle a channel can consume one credit and receive a return of several credits. Consumers gate sends on the registered per-channel status outputs. Unlike a bare counter, it clamps at both bounds and can report sticky overflow and underflow errors instead of silently wrapping.

---
 rtl/credit_pkg.sv | 22 ++
 rtl/credit_channel.sv | 89 ++++++++
 rtl/credit_pool.sv | 55 +++++
 tb/tb_credit_pool.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
// Shared types and width helpers for the credit_pool tracker.
package credit_pkg;

    // Bits needed to hold a credit count in the range 0..credits_max.
    function automatic int cnt_width(input int credits_max);
        return $clog2(credits_max + 1);
    endfunction

    // Bits needed to hold a per-cycle return in the range 0..ret_max.
    function automatic int ret_width(input int ret_max);
        return $clog2(ret_max + 1);
    endfunction

    // Per-channel status, decoded from the registered count and error flags.
    typedef struct packed {
        logic has_credit;
        logic low_credit;
        logic ovf;
        logic unf;
    } ch_status_t;

endpackage

// File: rtl/credit_channel.sv
// One saturating credit counter with watermark decode and optional sticky
// error flags. Error flags are built only when CREDIT_POOL_ERR_EN is defined.
module credit_channel
    import credit_pkg::*;
#(
    parameter int CREDITS_MAX = 8,
    parameter int LOW_WM      = 2,
    parameter int CNT_W       = 4,
    parameter int RET_W       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             take,
    input  logic [RET_W-1:0] ret_cnt,
    input  logic             err_clr,
    output logic [CNT_W-1:0] credits,
    output ch_status_t       status
);

    // Sum width covers count + largest encodable return - 1 with sign, so an
    // out-of-contract return still reaches the clamp instead of wrapping.
    localparam int SW = ((CNT_W > RET_W) ? CNT_W : RET_W) + 2;
    localparam logic signed [SW-1:0] MAX_S = SW'(CREDITS_MAX);

    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic signed [SW-1:0] sum;
    logic                 ovf_evt;
    logic                 unf_evt;
    logic                 ovf_q;
    logic                 unf_q;

    // Net the take against the return, then clamp at both bounds.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would infer a latch.
        cnt_d   = cnt_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        sum     = $signed({{(SW-CNT_W){1'b0}}, cnt_q})
                + $signed({{(SW-RET_W){1'b0}}, ret_cnt})
                - $signed({{(SW-1){1'b0}}, take});
        if (sum < 0) begin
            cnt_d   = '0;
            unf_evt = 1'b1;
        end else if (sum > MAX_S) begin
            cnt_d   = CNT_W'(CREDITS_MAX);
            ovf_evt = 1'b1;
        end else begin
            cnt_d   = sum[CNT_W-1:0];
        end
    end

    // Credit counter; reset refills the channel.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) cnt_q <= CNT_W'(CREDITS_MAX);
        else     cnt_q <= cnt_d;
    end

`ifdef CREDIT_POOL_ERR_EN
    // Sticky error flags; a new event in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt)      ovf_q <= 1'b1;
            else if (err_clr) ovf_q <= 1'b0;
            if (unf_evt)      unf_q <= 1'b1;
            else if (err_clr) unf_q <= 1'b0;
        end
    end
`else
    // Error tracking disabled: flags tied low, clear input has no effect.
    logic unused_err;
    assign unused_err = err_clr ^ ovf_evt ^ unf_evt;
    assign ovf_q      = 1'b0;
    assign unf_q      = 1'b0;
`endif

    assign credits           = cnt_q;
    assign status.has_credit = (cnt_q != '0);
    assign status.low_credit = (cnt_q <= CNT_W'(LOW_WM));
    assign status.ovf        = ovf_q;
    assign status.unf        = unf_q;

endmodule

// File: rtl/credit_pool.sv
// Multi-channel credit tracker for the transmit side of a credit-based link.
// Optional sticky error flags are enabled with the CREDIT_POOL_ERR_EN macro.
module credit_pool
    import credit_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CREDITS_MAX = 8,
    parameter int  RET_MAX     = 2,
    parameter int  LOW_WM      = 2,
    localparam int CNT_W       = cnt_width(CREDITS_MAX),
    localparam int RET_W       = ret_width(RET_MAX)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       take,
    input  logic [NUM_CH*RET_W-1:0] ret_cnt,
    input  logic                    err_clr,
    output logic [NUM_CH*CNT_W-1:0] credits,
    output logic [NUM_CH-1:0]       has_credit,
    output logic [NUM_CH-1:0]       low_credit,
    output logic                    all_full,
    output logic [NUM_CH-1:0]       err_ovf,
    output logic [NUM_CH-1:0]       err_unf
);

    ch_status_t        status [NUM_CH];
    logic [NUM_CH-1:0] full;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        credit_channel #(
            .CREDITS_MAX (CREDITS_MAX),
            .LOW_WM      (LOW_WM),
            .CNT_W       (CNT_W),
            .RET_W       (RET_W)
        ) u_channel (
            .clk     (clk),
            .rst     (rst),
            .take    (take[i]),
            .ret_cnt (ret_cnt[i*RET_W +: RET_W]),
            .err_clr (err_clr),
            .credits (credits[i*CNT_W +: CNT_W]),
            .status  (status[i])
        );

        assign has_credit[i] = status[i].has_credit;
        assign low_credit[i] = status[i].low_credit;
        assign err_ovf[i]    = status[i].ovf;
        assign err_unf[i]    = status[i].unf;
        assign full[i]       = (credits[i*CNT_W +: CNT_W] == CNT_W'(CREDITS_MAX));
    end

    // Link is drained only when every channel holds its full allocation.
    assign all_full = &full;

endmodule

// File: tb/tb_credit_pool.sv
// Self-checking bench for credit_pool: directed scenarios followed by random
// traffic, compared every cycle against a behavioural credit model.
module tb_credit_pool;

    localparam int NCH   = 4;
    localparam int CMAX  = 8;
    localparam int WM    = 2;
    localparam int CW    = 4;
    localparam int RW    = 2;
`ifdef CREDIT_POOL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NCH-1:0]      take;
    logic [NCH*RW-1:0]   ret_cnt;
    logic                err_clr;
    logic [NCH*CW-1:0]   credits;
    logic [NCH-1:0]      has_credit;
    logic [NCH-1:0]      low_credit;
    logic                all_full;
    logic [NCH-1:0]      err_ovf;
    logic [NCH-1:0]      err_unf;

    int checks = 0;
    int errors = 0;

    int m_cnt [NCH];
    bit m_ovf [NCH];
    bit m_unf [NCH];

    credit_pool dut (
        .clk        (clk),
        .rst        (rst),
        .take       (take),
        .ret_cnt    (ret_cnt),
        .err_clr    (err_clr),
        .credits    (credits),
        .has_credit (has_credit),
        .low_credit (low_credit),
        .all_full   (all_full),
        .err_ovf    (err_ovf),
        .err_unf    (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: each channel is an integer bank of credits clamped to 0..CMAX.
    task automatic model_update();
        for (int i = 0; i < NCH; i++) begin
            int s;
            bit ovf_e, unf_e;
            if (rst) begin
                m_cnt[i] = CMAX;
                m_ovf[i] = 0;
                m_unf[i] = 0;
            end else begin
                s = m_cnt[i] + int'(ret_cnt[i*RW +: RW]) - int'(take[i]);
                ovf_e = (s > CMAX);
                unf_e = (s < 0);
                m_cnt[i] = ovf_e ? CMAX : (unf_e ? 0 : s);
                m_ovf[i] = ERR_EN && (ovf_e || (m_ovf[i] && !err_clr));
                m_unf[i] = ERR_EN && (unf_e || (m_unf[i] && !err_clr));
            end
        end
    endtask

    task automatic compare_all(input string tag);
        bit full = 1;
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("%s cnt%0d", tag, i), 32'(credits[i*CW +: CW]), 32'(m_cnt[i]));
            check($sformatf("%s has%0d", tag, i), 32'(has_credit[i]), 32'(m_cnt[i] != 0));
            check($sformatf("%s low%0d", tag, i), 32'(low_credit[i]), 32'(m_cnt[i] <= WM));
            check($sformatf("%s ovf%0d", tag, i), 32'(err_ovf[i]), 32'(m_ovf[i]));
            check($sformatf("%s unf%0d", tag, i), 32'(err_unf[i]), 32'(m_unf[i]));
            if (m_cnt[i] != CMAX) full = 0;
        end
        check($sformatf("%s all_full", tag), 32'(all_full), 32'(full));
    endtask

    task automatic cycle(input string tag);
        model_update();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        take    = '0;
        ret_cnt = '0;
        err_clr = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle("reset");
        rst = 1'b0;
        cycle("idle");
        check("rst credits", 32'(credits), 32'h8888);
        check("rst has", 32'(has_credit), 32'hF);
        check("rst low", 32'(low_credit), 32'h0);
        check("rst full", 32'(all_full), 32'h1);
        check("rst errs", 32'({err_ovf, err_unf}), 32'h0);

        // Channel 0 drained by eight back-to-back takes.
        for (int k = 0; k < 8; k++) begin
            take = 4'b0001;
            cycle("drain0");
            check($sformatf("drain0 step%0d", k), 32'(credits[3:0]), 32'(7 - k));
        end
        check("drain0 has", 32'(has_credit[0]), 32'h0);
        check("drain0 low", 32'(low_credit[0]), 32'h1);
        check("drain0 full", 32'(all_full), 32'h0);

        // Channel 1: drain, then take+return netting, then underflow.
        take = 4'b0010;
        for (int k = 0; k < 8; k++) cycle("drain1");
        take = 4'b0010; ret_cnt = 8'b0000_1000;
        cycle("net1");
        check("net1 cnt", 32'(credits[7:4]), 32'h1);
        check("net1 unf", 32'(err_unf[1]), 32'h0);
        ret_cnt = '0;
        cycle("take1");
        check("take1 cnt", 32'(credits[7:4]), 32'h0);
        cycle("unf1");
        check("unf1 cnt", 32'(credits[7:4]), 32'h0);
        check("unf1 flag", 32'(err_unf[1]), 32'(ERR_EN));

        // Channel 2: take to 7, then return 2 clamps at 8.
        take = 4'b0100;
        cycle("take2");
        take = '0; ret_cnt = 8'b0010_0000;
        cycle("ovf2");
        check("ovf2 cnt", 32'(credits[11:8]), 32'h8);
        check("ovf2 flag", 32'(err_ovf[2]), 32'(ERR_EN));
        check("ovf2 others", 32'({credits[15:12], credits[7:0]}), 32'h800);
        ret_cnt = '0;

        // Channel 3: drain, underflow with err_clr in the same cycle, then clear.
        take = 4'b1000;
        for (int k = 0; k < 8; k++) cycle("drain3");
        err_clr = 1'b1;
        cycle("unf3 clr");
        check("unf3 set wins", 32'(err_unf[3]), 32'(ERR_EN));
        take = '0;
        cycle("clr");
        check("clr unf", 32'(err_unf), 32'h0);
        check("clr ovf", 32'(err_ovf), 32'h0);
        err_clr = 1'b0;

        // Random traffic including out-of-contract returns and mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            take    = 4'($urandom);
            ret_cnt = 8'($urandom);
            err_clr = ($urandom_range(15) == 0);
            rst     = ($urandom_range(63) == 0);
            cycle("rand");
            if (rst) begin
                check("rand rst credits", 32'(credits), 32'h8888);
                check("rand rst errs", 32'({err_ovf, err_unf}), 32'h0);
            end
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
